// File: rtl/img_pkg.sv
// img_pkg: frame geometry, state encoding and threshold defaults shared along the edge pipeline
package img_pkg;
    localparam int IMG_W = 640;
    localparam int IMG_H = 480;
    localparam logic [7:0] DEF_THRESH = 8'd128;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Binarise one grayscale pixel: unsigned 8-bit compare, so thr=0 passes everything
    function automatic logic to_bin(input logic [7:0] gray, input logic [7:0] thr);
        return gray >= thr;
    endfunction
endpackage

// File: rtl/bin_stream_tx_if.sv
// bin_stream_tx_if: binary pixel stream consumed by the Sobel stage
//   dout     binary pixel
//   dout_vld dout valid this cycle
//   dout_sop first pixel of frame (only with dout_vld)
//   dout_eop last pixel of frame (only with dout_vld)
interface bin_stream_tx_if;
    logic dout;
    logic dout_vld;
    logic dout_sop;
    logic dout_eop;

    modport master (output dout, dout_vld, dout_sop, dout_eop);
    modport slave  (input  dout, dout_vld, dout_sop, dout_eop);
endinterface

// File: rtl/pix_counter.sv
// pix_counter: raster column/row counter with enable, sync clear and end-of-line/frame flags
//   clk, rst_n      clock, async active-low reset
//   en              advance one pixel
//   clr             restart at (0,0); with en the advance applies on top of the restart
//   col, row        current position
//   last_col        col is the last column
//   last_pix        position is the last pixel of the frame
module pix_counter #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int COL_W = 10,
    parameter int ROW_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last_col,
    output logic             last_pix
);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col_q, col_d, col_b;
    logic [ROW_W-1:0] row_q, row_d, row_b;

    always_comb begin
        col_b = clr ? '0 : col_q;
        row_b = clr ? '0 : row_q;
        col_d = col_b;
        row_d = row_b;
        if (en) begin
            col_d = (col_b == COL_LAST) ? '0 : col_b + COL_W'(1);
            row_d = (col_b != COL_LAST) ? row_b : (row_b == ROW_LAST) ? '0 : row_b + ROW_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col      = col_q;
    assign row      = row_q;
    assign last_col = col_q == COL_LAST;
    assign last_pix = last_col && (row_q == ROW_LAST);
endmodule

// File: rtl/bin_stream_tx.sv
// bin_stream_tx: thresholds a framed grayscale stream to 1 bit and transmits it with sop/eop framing
//   clk, rst_n   clock, async active-low reset
//   gray_in/vld  camera pixel and its valid
//   frame_start  next (or coincident) accepted pixel is (0,0)
//   cfg_thresh   threshold, latched at frame start
//   bs           binary stream out (master)
//   busy         frame in progress
//   frame_err    one-cycle pulse when a frame is aborted by an early frame_start
//   abort_cnt    saturating count of aborted frames
module bin_stream_tx #(
    parameter int         IMG_W      = img_pkg::IMG_W,
    parameter int         IMG_H      = img_pkg::IMG_H,
    parameter int         COL_W      = 10,
    parameter int         ROW_W      = 9,
    parameter logic [7:0] DEF_THRESH = img_pkg::DEF_THRESH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            gray_in,
    input  logic                  gray_vld,
    input  logic                  frame_start,
    input  logic [7:0]            cfg_thresh,
    bin_stream_tx_if.master       bs,
    output logic                  busy,
    output logic                  frame_err,
    output logic [7:0]            abort_cnt
);
    import img_pkg::*;

    state_t           state_q, state_d;
    logic [7:0]       thresh_q, thresh_d;
    logic [7:0]       abort_cnt_q, abort_cnt_d;
    logic             dout_q, dout_d, vld_q, vld_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             last_col, last_pix;
    logic             active, acc, eop_now, fs_new, abort;

    assign active  = state_q == ST_ACTIVE;
    assign acc     = gray_vld && (active || frame_start);
    assign eop_now = active && gray_vld && last_col && last_pix;
    // A frame_start landing on the eop pixel just chains the next frame; otherwise it
    // restarts at (0,0), and while ACTIVE that restart is an abort.
    assign fs_new  = frame_start && !eop_now;
    assign abort   = active && fs_new;

    pix_counter #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .COL_W(COL_W),
        .ROW_W(ROW_W)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (acc),
        .clr     (fs_new),
        .col     (col),
        .row     (row),
        .last_col(last_col),
        .last_pix(last_pix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = frame_start ? ST_ACTIVE : eop_now ? ST_IDLE : state_q;
    end

    // A pixel opening a new frame is judged against the threshold being latched now
    always_comb begin
        thresh_d    = frame_start ? cfg_thresh : thresh_q;
        dout_d      = acc && to_bin(gray_in, fs_new ? cfg_thresh : thresh_q);
        vld_d       = acc;
        sop_d       = acc && (fs_new || (col == '0 && row == '0));
        eop_d       = eop_now;
        err_d       = abort;
        abort_cnt_d = (abort && abort_cnt_q != 8'hFF) ? abort_cnt_q + 8'd1 : abort_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thresh_q    <= DEF_THRESH;
            abort_cnt_q <= '0;
            dout_q      <= 1'b0;
            vld_q       <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            thresh_q    <= thresh_d;
            abort_cnt_q <= abort_cnt_d;
            dout_q      <= dout_d;
            vld_q       <= vld_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            err_q       <= err_d;
        end
    end

    assign bs.dout     = dout_q;
    assign bs.dout_vld = vld_q;
    assign bs.dout_sop = sop_q;
    assign bs.dout_eop = eop_q;
    assign busy        = active;
    assign frame_err   = err_q;
    assign abort_cnt   = abort_cnt_q;
endmodule

// File: doc/bin_stream_tx.md
Name: bin_stream_tx

Overview:
Front end of the binary edge pipeline. Takes a camera grayscale pixel stream (8-bit, valid-qualified, with a frame-start pulse) and thresholds each pixel to 1 bit. Counts columns and rows, and emits the binary din/din_vld/din_sop/din_eop stream that the Sobel stage consumes. It is the transmitter for that interface and owns frame framing and frame-error detection.

Parameters:
IMG_W, 640, active pixels per line (>=2)
IMG_H, 480, active lines per frame (>=2)
COL_W, 10, column counter width; 2^COL_W >= IMG_W
ROW_W, 9, row counter width; 2^ROW_W >= IMG_H
DEF_THRESH, 8'd128, threshold loaded at reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
gray_in  in  8  grayscale pixel
gray_vld  in  1  gray_in valid this cycle
frame_start  in  1  one-cycle pulse; marks that the next accepted pixel (or a coincident one) is pixel (0,0)
cfg_thresh  in  8  runtime threshold, sampled only at frame start
dout  out  1  binary pixel: 1 if gray_in >= latched threshold, else 0
dout_vld  out  1  dout valid
dout_sop  out  1  first pixel of frame, coincident with dout_vld
dout_eop  out  1  last pixel of frame, coincident with dout_vld
busy  out  1  1 while in ACTIVE
frame_err  out  1  one-cycle pulse: frame aborted by early frame_start
abort_cnt  out  8  saturating count of aborted frames

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; counters 0; latched threshold = DEF_THRESH.
- States: IDLE, ACTIVE.
- IDLE: gray_vld is ignored and the pixel is dropped, with no output. On frame_start: go to ACTIVE, latch cfg_thresh, col=0, row=0. If gray_vld is high in the same cycle, that pixel is accepted as (0,0).
- ACTIVE: each cycle with gray_vld=1 accepts one pixel. Cycles with gray_vld=0 produce no output (dout_vld=0) and hold the counters.
- Latency: exactly 1 cycle, accepted pixel to dout_vld. All outputs are registered.
- dout_sop=1 iff the accepted pixel is col=0,row=0. dout_eop=1 iff col=IMG_W-1,row=IMG_H-1. sop/eop are 0 whenever dout_vld=0.
- Counter: col increments per accepted pixel. At IMG_W-1, col wraps to 0 and row increments. After the eop pixel: state goes to IDLE and counters return to 0.
- Width rule: compare as unsigned 8-bit. Threshold 0 gives all 1s; threshold 255 gives 1 only for 255.
- frame_start while ACTIVE, eop not yet accepted (abort):
  - frame_err pulses 1 cycle later; abort_cnt increments, saturating at 255.
  - Threshold is relatched and counters restart at (0,0); state stays ACTIVE.
  - No eop is ever emitted for the aborted frame.
  - A coincident gray_vld pixel is pixel (0,0) of the new frame, with sop=1.
- frame_start in the same cycle as the eop pixel: the eop is emitted normally with no abort, and a new frame starts (state ACTIVE). A coincident pixel cannot exist separately; the eop pixel belongs to the old frame.
- cfg_thresh changes mid-frame have no effect until the next frame start.
- Reset mid-frame: immediate return to IDLE; outputs 0 asynchronously; abort_cnt cleared.
- dout_vld/sop/eop never assert without a preceding accepted pixel.

Decomposition:
- Shared package img_pkg:
  - IMG_W/IMG_H defaults
  - state encoding constants ST_IDLE=1'b0, ST_ACTIVE=1'b1
  - DEF_THRESH
  - These are shared with the Sobel and downstream blocks.
- One sub-module: pix_counter, the col/row counter with enable, sync clear, and last_col/last_pix flags. It is reusable by downstream frame checkers.

Test Plan:
1. IMG_W=4, IMG_H=3, cfg_thresh=100, frame_start then 12 consecutive pixels of value 99,100,... -> 12 dout_vld cycles, each 1 cycle after input. sop on the 1st only, eop on the 12th only; dout=0 for 99 and 1 for >=100; busy drops after eop.
2. Same frame with gray_vld toggling 1,0,1,0 -> output gaps mirror input gaps; sop/eop still on pixels 1 and 12; counters hold during gaps.
3. Pixels with gray_vld=1 before any frame_start -> dout_vld stays 0, busy=0.
4. frame_start after 5 pixels -> frame_err pulses once and abort_cnt=1. The next pixel carries sop=1, and the full 12 pixels after it produce exactly one eop.
5. cfg_thresh changed 200->50 mid-frame -> the current frame still uses 200; the next frame uses 50. Check the corner values 0 and 255.
6. rst_n low for 1 cycle mid-frame -> outputs 0 immediately, abort_cnt=0, state IDLE; the following frame_start begins a clean frame with sop on the first pixel.
